pomdp_env: RTL and testbench
============================

Name: pomdp_env

Overview:
- Environment responder for the POMDP agent. Accepts one action per step over a valid/ready handshake.
- Per step: samples the next hidden state from trans[a][s]; samples an observation from observe[a][s']; returns observation and reward; accumulates discounted reward.
- Sits opposite the policy/agent side of the whole_flow loop and drives closed-loop simulation and scoring of solved policies.
- Probabilities are unsigned Q0.16.

Parameters:
- MAX_STEPS_W, 16, width of the episode step limit and step counter.
- ACC_W, 32, width of the discounted-reward accumulator.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; loads initial_state, seeds, clears accumulators
- initial_state  in  1  state loaded on start
- seed0  in  16  LFSR seed, state sampling
- seed1  in  16  LFSR seed, observation sampling
- max_steps  in  16  episode length; 0 = unlimited
- discount  in  16  Q0.16 discount factor
- trans  in  16 x [3][2][2]  trans[a][s][s'] probability
- observe  in  16 x [3][2][2]  observe[a][s'][o] probability
- vec_reward  in  16 x [3][2]  reward[a][s]
- act_valid  in  1  action offered
- action  in  2  action index 0..2
- act_ready  out  1  environment can accept an action
- obs_valid  out  1  step result valid
- obs_ready  in  1  agent consumes the result
- observation  out  1  sampled observation
- cur_state  out  1  current hidden state (debug)
- reward  out  16  immediate reward of the step
- total_reward  out  32  discounted cumulative reward
- step_cnt  out  16  completed steps
- done  out  1  episode finished

Behaviour:
- Reset, synchronous active-high, dominates start. All outputs 0. FSM = IDLE. LFSR state = 16'h0001. disc_pow = 17'h10000 (1.0).
  - Reset mid-step aborts the step with no partial updates.
- FSM states: IDLE, WAIT_ACT, SAMPLE_S, SAMPLE_O, RESPOND, DONE.
- start, accepted in any non-reset state:
  - cur_state <= initial_state.
  - LFSRs <= seed; seed 0 is replaced by 16'h0001.
  - total_reward, step_cnt, done <= 0; disc_pow <= 1.0.
  - Next state = WAIT_ACT. An in-flight step is dropped and obs_valid deasserts.
- WAIT_ACT:
  - act_ready = 1.
  - On act_valid & act_ready: latch action. An action value of 3 is treated as 2.
  - Go to SAMPLE_S.
- SAMPLE_S, 1 cycle:
  - r0 = lfsr0 value. next = (r0 <= trans[a][s][0]) ? 0 : 1.
  - lfsr0 advances one step.
  - reward <= vec_reward[a][s], using the pre-transition state.
- SAMPLE_O, 1 cycle:
  - r1 = lfsr1 value. o = (r1 <= observe[a][next][0]) ? 0 : 1.
  - lfsr1 advances.
  - cur_state <= next; observation <= o.
  - total_reward += (disc_pow * reward) >> 16, with 33x16 product truncation and wrap at 2^32.
  - disc_pow <= (disc_pow * discount) >> 16.
  - step_cnt++.
- RESPOND:
  - obs_valid = 1; observation and reward are held stable until obs_ready.
  - On obs_ready: if max_steps != 0 and step_cnt == max_steps, go to DONE; otherwise go to WAIT_ACT.
- DONE: done = 1, act_ready = 0. Leaves only on start or rst.
- Latency: accept at cycle T; obs_valid at T+3. Sustained throughput 1 step per 4 cycles when obs_ready is tied high.
- LFSR sampling properties:
  - The LFSR never yields 0, so p0 = 16'h0000 always selects index 1.
  - p0 = 16'hffff always selects index 0.
- act_ready = 0 in every state except WAIT_ACT. act_valid outside WAIT_ACT is ignored, not queued.
- Table inputs are sampled combinationally during SAMPLE_*. They must be stable for the episode.

Decomposition:
- pomdp_pkg holds:
  - N_ACTION=3, N_STATE=2, N_OBS=2.
  - prob_t (logic [15:0]), action_t (logic [1:0]).
  - LFSR_TAPS = 16'hB400.
  - env_state_e enum.
- One sub-module: lfsr16, a Galois LFSR (x^16+x^14+x^13+x^11+1) with load/seed, zero-seed fixup, and step enable. Instantiated twice.

Test Plan:
- Reset then start with initial_state=0. Action 0 with vec_reward[0][0]=7209 and trans[0][0][0]=ffff -> obs_valid at T+3, reward=7209, cur_state=0, total_reward=7209, step_cnt=1.
- Second step, same action, discount=16'hc000 -> reward=7209, total_reward=7209+5406=12615.
- trans[2]={{0000,ffff},{ffff,0000}} and observe[2][s'][0]=(s'==0?ffff:0000), action 2 repeated from state 0 -> cur_state toggles 1,0,1; observation equals cur_state each step.
- max_steps=2 -> after the 2nd obs_ready: done=1, act_ready=0; further act_valid is ignored. start returns the block to WAIT_ACT with step_cnt=0.
- obs_ready held low for 5 cycles -> obs_valid, observation, and reward stay stable; no new action is accepted.
- seed0=seed1=0 with trans 8000 -> behaves identically to seed 16'h0001 (bench checks against a golden LFSR model). Asserting rst mid-SAMPLE_O -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pomdp_pkg.sv
// Shared types and constants for the POMDP environment responder.
// Probabilities are unsigned Q0.16; tables arrive flattened, one 16-bit word per entry.
package pomdp_pkg;
  localparam int N_ACTION = 3;
  localparam int N_STATE  = 2;
  localparam int N_OBS    = 2;
  localparam int PROB_W   = 16;

  localparam int TRANS_W = N_ACTION * N_STATE * N_STATE * PROB_W;
  localparam int OBS_W   = N_ACTION * N_STATE * N_OBS * PROB_W;
  localparam int RWD_W   = N_ACTION * N_STATE * PROB_W;

  typedef logic [PROB_W-1:0] prob_t;
  typedef logic [1:0]        action_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [16:0] DISC_ONE  = 17'h10000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACT,
    SAMPLE_S,
    SAMPLE_O,
    RESPOND,
    DONE
  } env_state_e;
endpackage

// File: rtl/pomdp_env_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed load and step enable.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module lfsr16
  import pomdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0001;
    end else if (load) begin
      value <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      value <= value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/pomdp_env.sv
// POMDP environment: accepts one action per step, samples next hidden state and
// observation from Q0.16 tables, returns reward and keeps a discounted running total.
module pomdp_env
  import pomdp_pkg::*;
#(
  parameter int MAX_STEPS_W = 16,
  parameter int ACC_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   initial_state,
  input  logic [15:0]            seed0,
  input  logic [15:0]            seed1,
  input  logic [MAX_STEPS_W-1:0] max_steps,
  input  logic [15:0]            discount,
  input  logic [TRANS_W-1:0]     trans,
  input  logic [OBS_W-1:0]       observe,
  input  logic [RWD_W-1:0]       vec_reward,
  input  logic                   act_valid,
  input  logic [1:0]             action,
  output logic                   act_ready,
  output logic                   obs_valid,
  input  logic                   obs_ready,
  output logic                   observation,
  output logic                   cur_state,
  output logic [15:0]            reward,
  output logic [ACC_W-1:0]       total_reward,
  output logic [MAX_STEPS_W-1:0] step_cnt,
  output logic                   done
);

  env_state_e  state;
  action_t     act_p0;
  logic        nxt_p1;
  logic [16:0] disc_pow;
  logic [15:0] lfsr0_val;
  logic [15:0] lfsr1_val;

  prob_t trans0 [N_ACTION][N_STATE];
  prob_t obs0   [N_ACTION][N_STATE];
  prob_t rwd    [N_ACTION][N_STATE];
  logic [N_ACTION*N_STATE-1:0] unused_hi;

  // Only the index-0 column is needed: index 1 is the complement of the same draw.
  for (genvar a = 0; a < N_ACTION; a++) begin : g_act
    for (genvar s = 0; s < N_STATE; s++) begin : g_st
      localparam int ROW = a * N_STATE + s;
      assign trans0[a][s] = trans[(ROW * N_STATE) * PROB_W +: PROB_W];
      assign obs0[a][s]   = observe[(ROW * N_OBS) * PROB_W +: PROB_W];
      assign rwd[a][s]    = vec_reward[ROW * PROB_W +: PROB_W];
      assign unused_hi[ROW] = ^{trans[(ROW * N_STATE + 1) * PROB_W +: PROB_W],
                                observe[(ROW * N_OBS + 1) * PROB_W +: PROB_W]};
    end
  end

  function automatic logic [ACC_W-1:0] disc_term(input logic [16:0] pow, input prob_t rw);
    logic [32:0] prod;
    prod = 33'(pow) * 33'(rw);
    return ACC_W'(prod[32:16]);
  endfunction

  function automatic logic [16:0] disc_scale(input logic [16:0] pow, input logic [15:0] df);
    logic [32:0] prod;
    prod = 33'(pow) * 33'(df);
    return prod[32:16];
  endfunction

  lfsr16 u_lfsr_s (
    .clk   (clk),
    .rst   (rst),
    .load  (start),
    .step  (state == SAMPLE_S),
    .seed  (seed0),
    .value (lfsr0_val)
  );

  lfsr16 u_lfsr_o (
    .clk   (clk),
    .rst   (rst),
    .load  (start),
    .step  (state == SAMPLE_O),
    .seed  (seed1),
    .value (lfsr1_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      act_p0       <= '0;
      nxt_p1       <= 1'b0;
      disc_pow     <= DISC_ONE;
      act_ready    <= 1'b0;
      obs_valid    <= 1'b0;
      observation  <= 1'b0;
      cur_state    <= 1'b0;
      reward       <= '0;
      total_reward <= '0;
      step_cnt     <= '0;
      done         <= 1'b0;
    end else if (start) begin
      state        <= WAIT_ACT;
      cur_state    <= initial_state;
      disc_pow     <= DISC_ONE;
      total_reward <= '0;
      step_cnt     <= '0;
      done         <= 1'b0;
      act_ready    <= 1'b1;
      obs_valid    <= 1'b0;
    end else begin
      case (state)
        // Stage 0: action handshake
        WAIT_ACT: begin
          if (act_valid && act_ready) begin
            act_p0    <= (action == 2'd3) ? 2'd2 : action;
            act_ready <= 1'b0;
            state     <= SAMPLE_S;
          end
        end
        // Stage 1: hidden-state draw, reward from the pre-transition state
        SAMPLE_S: begin
          nxt_p1 <= (lfsr0_val <= trans0[act_p0][cur_state]) ? 1'b0 : 1'b1;
          reward <= rwd[act_p0][cur_state];
          state  <= SAMPLE_O;
        end
        // Stage 2: observation draw and accumulator update
        SAMPLE_O: begin
          cur_state    <= nxt_p1;
          observation  <= (lfsr1_val <= obs0[act_p0][nxt_p1]) ? 1'b0 : 1'b1;
          total_reward <= total_reward + disc_term(disc_pow, reward);
          disc_pow     <= disc_scale(disc_pow, discount);
          step_cnt     <= step_cnt + MAX_STEPS_W'(1);
          obs_valid    <= 1'b1;
          state        <= RESPOND;
        end
        RESPOND: begin
          if (obs_ready) begin
            obs_valid <= 1'b0;
            if ((max_steps != '0) && (step_cnt == max_steps)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              act_ready <= 1'b1;
              state     <= WAIT_ACT;
            end
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pomdp_env.sv
// Directed testbench for pomdp_env: hand-computed vectors plus a small LFSR model
// for the pseudo-random sampling scenario.
module tb_pomdp_env;
  import pomdp_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic               initial_state;
  logic [15:0]        seed0;
  logic [15:0]        seed1;
  logic [15:0]        max_steps;
  logic [15:0]        discount;
  logic [TRANS_W-1:0] trans;
  logic [OBS_W-1:0]   observe;
  logic [RWD_W-1:0]   vec_reward;
  logic               act_valid;
  logic [1:0]         action;
  logic               act_ready;
  logic               obs_valid;
  logic               obs_ready;
  logic               observation;
  logic               cur_state;
  logic [15:0]        reward;
  logic [31:0]        total_reward;
  logic [15:0]        step_cnt;
  logic               done;

  int vec;
  int errs;

  pomdp_env #(.MAX_STEPS_W(16), .ACC_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .initial_state (initial_state),
    .seed0         (seed0),
    .seed1         (seed1),
    .max_steps     (max_steps),
    .discount      (discount),
    .trans         (trans),
    .observe       (observe),
    .vec_reward    (vec_reward),
    .act_valid     (act_valid),
    .action        (action),
    .act_ready     (act_ready),
    .obs_valid     (obs_valid),
    .obs_ready     (obs_ready),
    .observation   (observation),
    .cur_state     (cur_state),
    .reward        (reward),
    .total_reward  (total_reward),
    .step_cnt      (step_cnt),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_t(input int a, input int s, input int k, input logic [15:0] v);
    trans[((a * 2 + s) * 2 + k) * 16 +: 16] = v;
  endtask

  task automatic set_o(input int a, input int s, input int k, input logic [15:0] v);
    observe[((a * 2 + s) * 2 + k) * 16 +: 16] = v;
  endtask

  task automatic set_r(input int a, input int s, input logic [15:0] v);
    vec_reward[(a * 2 + s) * 16 +: 16] = v;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = {1'b0, x[15:1]};
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer an action, wait for the handshake, then for obs_valid; checks latency.
  task automatic do_step(input logic [1:0] a);
    int n;
    int lat;
    act_valid = 1'b1;
    action    = a;
    n = 0;
    while (!act_ready && n < 20) begin
      tick();
      n++;
    end
    vec++;
    if (act_ready !== 1'b1) begin
      errs++;
      $display("FAIL step_accept_timeout act_ready=%0b want 1", act_ready);
    end
    tick();
    act_valid = 1'b0;
    lat = 1;
    while (!obs_valid && lat < 20) begin
      tick();
      lat++;
    end
    vec++;
    if (lat != 3) begin
      errs++;
      $display("FAIL step_latency got %0d cycles want 3", lat);
    end
  endtask

  task automatic consume();
    obs_ready = 1'b1;
    tick();
    obs_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    vec++; if (act_ready !== 1'b0) begin errs++; $display("FAIL reset_act_ready got %0b want 0", act_ready); end
    vec++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL reset_obs_valid got %0b want 0", obs_valid); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %0b want 0", done); end
    vec++; if (step_cnt !== 16'd0) begin errs++; $display("FAIL reset_step_cnt got %0d want 0", step_cnt); end
    vec++; if (total_reward !== 32'd0) begin errs++; $display("FAIL reset_total got %0d want 0", total_reward); end
    vec++; if (reward !== 16'd0) begin errs++; $display("FAIL reset_reward got %0d want 0", reward); end
    rst = 1'b0;
    tick();
    vec++; if (act_ready !== 1'b0) begin errs++; $display("FAIL idle_act_ready got %0b want 0", act_ready); end
  endtask

  task automatic test_first_step();
    discount      = 16'hc000;
    max_steps     = 16'd0;
    seed0         = 16'hACE1;
    seed1         = 16'h1234;
    initial_state = 1'b0;
    set_t(0, 0, 0, 16'hffff); set_t(0, 0, 1, 16'h0000);
    set_o(0, 0, 0, 16'hffff); set_o(0, 0, 1, 16'h0000);
    set_r(0, 0, 16'd7209);
    pulse_start();
    vec++; if (act_ready !== 1'b1) begin errs++; $display("FAIL start_act_ready got %0b want 1", act_ready); end
    do_step(2'd0);
    vec++; if (reward !== 16'd7209) begin errs++; $display("FAIL first_reward got %0d want 7209", reward); end
    vec++; if (cur_state !== 1'b0) begin errs++; $display("FAIL first_state got %0b want 0", cur_state); end
    vec++; if (total_reward !== 32'd7209) begin errs++; $display("FAIL first_total got %0d want 7209", total_reward); end
    vec++; if (step_cnt !== 16'd1) begin errs++; $display("FAIL first_step_cnt got %0d want 1", step_cnt); end
    vec++; if (observation !== 1'b0) begin errs++; $display("FAIL first_obs got %0b want 0", observation); end
    consume();
  endtask

  task automatic test_discount();
    do_step(2'd0);
    vec++; if (reward !== 16'd7209) begin errs++; $display("FAIL disc_reward got %0d want 7209", reward); end
    vec++; if (total_reward !== 32'd12615) begin errs++; $display("FAIL disc_total got %0d want 12615", total_reward); end
    vec++; if (step_cnt !== 16'd2) begin errs++; $display("FAIL disc_step_cnt got %0d want 2", step_cnt); end
    consume();
  endtask

  task automatic test_toggle();
    logic        exp_s;
    logic [15:0] exp_r;
    set_t(2, 0, 0, 16'h0000); set_t(2, 0, 1, 16'hffff);
    set_t(2, 1, 0, 16'hffff); set_t(2, 1, 1, 16'h0000);
    set_o(2, 0, 0, 16'hffff); set_o(2, 0, 1, 16'h0000);
    set_o(2, 1, 0, 16'h0000); set_o(2, 1, 1, 16'hffff);
    set_r(2, 0, 16'd100);
    set_r(2, 1, 16'd200);
    initial_state = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      exp_s = (i % 2 == 0) ? 1'b1 : 1'b0;
      exp_r = (i % 2 == 0) ? 16'd100 : 16'd200;
      do_step((i == 3) ? 2'd3 : 2'd2);
      vec++; if (cur_state !== exp_s) begin errs++; $display("FAIL toggle_state[%0d] got %0b want %0b", i, cur_state, exp_s); end
      vec++; if (observation !== exp_s) begin errs++; $display("FAIL toggle_obs[%0d] got %0b want %0b", i, observation, exp_s); end
      vec++; if (reward !== exp_r) begin errs++; $display("FAIL toggle_reward[%0d] got %0d want %0d", i, reward, exp_r); end
      consume();
    end
  endtask

  task automatic test_max_steps();
    max_steps     = 16'd2;
    initial_state = 1'b0;
    pulse_start();
    do_step(2'd0);
    consume();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL max_mid_done got %0b want 0", done); end
    vec++; if (act_ready !== 1'b1) begin errs++; $display("FAIL max_mid_ready got %0b want 1", act_ready); end
    do_step(2'd0);
    consume();
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL max_done got %0b want 1", done); end
    vec++; if (act_ready !== 1'b0) begin errs++; $display("FAIL max_act_ready got %0b want 0", act_ready); end
    act_valid = 1'b1;
    action    = 2'd0;
    for (int i = 0; i < 4; i++) tick();
    act_valid = 1'b0;
    vec++; if (step_cnt !== 16'd2) begin errs++; $display("FAIL done_ignore_cnt got %0d want 2", step_cnt); end
    vec++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL done_ignore_valid got %0b want 0", obs_valid); end
    pulse_start();
    vec++; if (act_ready !== 1'b1) begin errs++; $display("FAIL restart_ready got %0b want 1", act_ready); end
    vec++; if (step_cnt !== 16'd0) begin errs++; $display("FAIL restart_cnt got %0d want 0", step_cnt); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL restart_done got %0b want 0", done); end
    max_steps = 16'd0;
  endtask

  task automatic test_backpressure();
    initial_state = 1'b0;
    pulse_start();
    do_step(2'd0);
    act_valid = 1'b1;
    action    = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++; if (obs_valid !== 1'b1) begin errs++; $display("FAIL hold_valid[%0d] got %0b want 1", i, obs_valid); end
      vec++; if (reward !== 16'd7209) begin errs++; $display("FAIL hold_reward[%0d] got %0d want 7209", i, reward); end
      vec++; if (observation !== 1'b0) begin errs++; $display("FAIL hold_obs[%0d] got %0b want 0", i, observation); end
      vec++; if (act_ready !== 1'b0) begin errs++; $display("FAIL hold_ready[%0d] got %0b want 0", i, act_ready); end
      vec++; if (step_cnt !== 16'd1) begin errs++; $display("FAIL hold_cnt[%0d] got %0d want 1", i, step_cnt); end
    end
    act_valid = 1'b0;
    consume();
    tick();
    vec++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL hold_noqueue_valid got %0b want 0", obs_valid); end
    vec++; if (step_cnt !== 16'd1) begin errs++; $display("FAIL hold_noqueue_cnt got %0d want 1", step_cnt); end
  endtask

  task automatic test_back_to_back();
    initial_state = 1'b0;
    pulse_start();
    act_valid = 1'b1;
    action    = 2'd0;
    obs_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vec++; if (step_cnt !== 16'd3) begin errs++; $display("FAIL b2b_cnt got %0d want 3", step_cnt); end
    vec++; if (act_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready got %0b want 1", act_ready); end
    vec++; if (total_reward !== 32'd16670) begin errs++; $display("FAIL b2b_total got %0d want 16670", total_reward); end
    act_valid = 1'b0;
    obs_ready = 1'b0;
  endtask

  task automatic test_seed_zero();
    logic [15:0] l0;
    logic [15:0] l1;
    logic        es;
    logic        eo;
    for (int s = 0; s < 2; s++) begin
      set_t(1, s, 0, 16'h8000); set_t(1, s, 1, 16'h8000);
      set_o(1, s, 0, 16'h8000); set_o(1, s, 1, 16'h8000);
    end
    for (int pass = 0; pass < 2; pass++) begin
      seed0 = (pass == 0) ? 16'h0000 : 16'h0001;
      seed1 = seed0;
      initial_state = 1'b0;
      pulse_start();
      l0 = 16'h0001;
      l1 = 16'h0001;
      for (int i = 0; i < 5; i++) begin
        es = (l0 <= 16'h8000) ? 1'b0 : 1'b1;
        l0 = lfsr_next(l0);
        eo = (l1 <= 16'h8000) ? 1'b0 : 1'b1;
        l1 = lfsr_next(l1);
        do_step(2'd1);
        vec++; if (cur_state !== es) begin errs++; $display("FAIL seed_state[%0d][%0d] got %0b want %0b", pass, i, cur_state, es); end
        vec++; if (observation !== eo) begin errs++; $display("FAIL seed_obs[%0d][%0d] got %0b want %0b", pass, i, observation, eo); end
        consume();
      end
    end
  endtask

  task automatic test_reset_mid();
    initial_state = 1'b1;
    set_t(0, 1, 0, 16'hffff); set_t(0, 1, 1, 16'h0000);
    set_r(0, 1, 16'd500);
    pulse_start();
    do_step(2'd0);
    consume();
    act_valid = 1'b1;
    action    = 2'd0;
    tick();
    act_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vec++; if (obs_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got %0b want 0", obs_valid); end
    vec++; if (act_ready !== 1'b0) begin errs++; $display("FAIL rstmid_ready got %0b want 0", act_ready); end
    vec++; if (step_cnt !== 16'd0) begin errs++; $display("FAIL rstmid_cnt got %0d want 0", step_cnt); end
    vec++; if (total_reward !== 32'd0) begin errs++; $display("FAIL rstmid_total got %0d want 0", total_reward); end
    vec++; if (reward !== 16'd0) begin errs++; $display("FAIL rstmid_reward got %0d want 0", reward); end
    vec++; if (cur_state !== 1'b0) begin errs++; $display("FAIL rstmid_state got %0b want 0", cur_state); end
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL rstmid_done got %0b want 0", done); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    vec           = 0;
    errs          = 0;
    rst           = 1'b1;
    start         = 1'b0;
    initial_state = 1'b0;
    seed0         = 16'h0001;
    seed1         = 16'h0001;
    max_steps     = 16'd0;
    discount      = 16'h0000;
    trans         = '0;
    observe       = '0;
    vec_reward    = '0;
    act_valid     = 1'b0;
    action        = 2'd0;
    obs_ready     = 1'b0;

    test_reset();
    test_first_step();
    test_discount();
    test_toggle();
    test_max_steps();
    test_backpressure();
    test_back_to_back();
    test_seed_zero();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
